// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, client ids and tag helper for mem_arbiter
package mem_arb_pkg;
   typedef enum logic {IDLE = 1'b0, WDATA = 1'b1} state_t;
   localparam int CLIENT_IC = 0;
   localparam int CLIENT_DC = 1;
   function automatic int tag_msb(input int tag_w);
      return tag_w - 1;
   endfunction
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin picker that can hold a stalled grant
module mem_arb_rr import mem_arb_pkg::*; (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       lock,
   output logic [1:0] grant
);
   logic       ptr;
   logic       locked;
   logic [1:0] held;
   always_comb grant = locked ? held : (&req ? (ptr ? 2'b10 : 2'b01) : req);
   // pointer moves to the client that did not win the handshake
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ptr    <= 1'(CLIENT_IC);
         locked <= 1'b0;
         held   <= 2'b00;
      end else if (advance) begin
         ptr    <= ~grant[CLIENT_DC];
         locked <= 1'b0;
      end else if (lock) begin
         locked <= 1'b1;
         held   <= grant;
      end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: icache/dcache to external memory arbiter; MEM_ARB_PERF_EN adds perf counters
module mem_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W      = 28,
   parameter int DATA_W      = 128,
   parameter int TAG_W       = 5,
   parameter int DATA_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ic_req_valid,
   output logic                ic_req_ready,
   input  logic [ADDR_W-1:0]   ic_req_addr,
   input  logic [TAG_W-2:0]    ic_req_tag,
   output logic                ic_resp_valid,
   output logic [DATA_W-1:0]   ic_resp_data,
   output logic [TAG_W-2:0]    ic_resp_tag,
   input  logic                dc_req_valid,
   output logic                dc_req_ready,
   input  logic                dc_req_rw,
   input  logic [ADDR_W-1:0]   dc_req_addr,
   input  logic [TAG_W-2:0]    dc_req_tag,
   input  logic                dc_req_data_valid,
   output logic                dc_req_data_ready,
   input  logic [DATA_W-1:0]   dc_req_data_bits,
   input  logic [DATA_W/8-1:0] dc_req_data_mask,
   output logic                dc_resp_valid,
   output logic [DATA_W-1:0]   dc_resp_data,
   output logic [TAG_W-2:0]    dc_resp_tag,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_rw,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [TAG_W-1:0]    mem_req_tag,
   output logic                mem_req_data_valid,
   input  logic                mem_req_data_ready,
   output logic [DATA_W-1:0]   mem_req_data_bits,
   output logic [DATA_W/8-1:0] mem_req_data_mask,
   input  logic                mem_resp_valid,
   input  logic [TAG_W-1:0]    mem_resp_tag,
   input  logic [DATA_W-1:0]   mem_resp_data
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]         perf_ic_grants,
   output logic [31:0]         perf_dc_grants,
   output logic [31:0]         perf_conflicts
`endif
);
   localparam int BW = DATA_CYCLES > 1 ? $clog2(DATA_CYCLES) : 1;
   localparam int TM = tag_msb(TAG_W);
   localparam logic [BW-1:0] LAST = BW'(DATA_CYCLES - 1);
   state_t        state;
   logic [BW-1:0] beat;
   logic [1:0]    req;
   logic [1:0]    grant;
   logic          idle;
   logic          dc_win;
   logic          hs;
   logic          dhs;
   always_comb idle = state == IDLE;
   always_comb req = idle ? {dc_req_valid, ic_req_valid} : 2'b00;
   mem_arb_rr u_rr (
      .clk     (clk),
      .rst     (reset),
      .req     (req),
      .advance (hs),
      .lock    (mem_req_valid && !mem_req_ready),
      .grant   (grant)
   );
   always_comb begin
      dc_win             = grant[CLIENT_DC];
      mem_req_valid      = !reset && idle && |(grant & {dc_req_valid, ic_req_valid});
      mem_req_rw         = dc_win && dc_req_rw;
      mem_req_addr       = dc_win ? dc_req_addr : ic_req_addr;
      mem_req_tag        = {dc_win, dc_win ? dc_req_tag : ic_req_tag};
      ic_req_ready       = mem_req_valid && grant[CLIENT_IC] && mem_req_ready;
      dc_req_ready       = mem_req_valid && dc_win && mem_req_ready;
      hs                 = mem_req_valid && mem_req_ready;
      mem_req_data_valid = !reset && !idle && dc_req_data_valid;
      dc_req_data_ready  = !reset && !idle && mem_req_data_ready;
      mem_req_data_bits  = dc_req_data_bits;
      mem_req_data_mask  = dc_req_data_mask;
      dhs                = mem_req_data_valid && mem_req_data_ready;
      ic_resp_valid      = !reset && mem_resp_valid && !mem_resp_tag[TM];
      dc_resp_valid      = !reset && mem_resp_valid && mem_resp_tag[TM];
      ic_resp_data       = mem_resp_data;
      dc_resp_data       = mem_resp_data;
      ic_resp_tag        = mem_resp_tag[TM-1:0];
      dc_resp_tag        = mem_resp_tag[TM-1:0];
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         beat  <= '0;
      end else if (idle) begin
         if (hs && dc_win && dc_req_rw) begin
            state <= WDATA;
            beat  <= '0;
         end
      end else if (dhs) begin
         state <= beat == LAST ? IDLE : WDATA;
         beat  <= beat == LAST ? '0 : beat + BW'(1);
      end
`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         perf_ic_grants <= '0;
         perf_dc_grants <= '0;
         perf_conflicts <= '0;
      end else begin
         if (hs && !dc_win && perf_ic_grants != '1) perf_ic_grants <= perf_ic_grants + 32'd1;
         if (hs && dc_win && perf_dc_grants != '1) perf_dc_grants <= perf_dc_grants + 32'd1;
         if (idle && ic_req_valid && dc_req_valid && perf_conflicts != '1) perf_conflicts <= perf_conflicts + 32'd1;
      end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;
   localparam int AW = 28, DW = 128, TW = 5, DC = 4, MW = DW / 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ic_req_valid, ic_req_ready, ic_resp_valid;
   logic [AW-1:0] ic_req_addr;
   logic [TW-2:0] ic_req_tag, ic_resp_tag;
   logic [DW-1:0] ic_resp_data;
   logic dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready, dc_resp_valid;
   logic [AW-1:0] dc_req_addr;
   logic [TW-2:0] dc_req_tag, dc_resp_tag;
   logic [DW-1:0] dc_req_data_bits, dc_resp_data;
   logic [MW-1:0] dc_req_data_mask;
   logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
   logic [AW-1:0] mem_req_addr;
   logic [TW-1:0] mem_req_tag, mem_resp_tag;
   logic [DW-1:0] mem_req_data_bits, mem_resp_data;
   logic [MW-1:0] mem_req_data_mask;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_ic_grants, perf_dc_grants, perf_conflicts;
`endif

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .DATA_CYCLES(DC)) dut (
      .clk(clk), .reset(reset),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_tag(ic_resp_tag),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
      .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag),
      .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
      .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_tag(dc_resp_tag),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
      .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
`ifdef MEM_ARB_PERF_EN
      , .perf_ic_grants(perf_ic_grants), .perf_dc_grants(perf_dc_grants), .perf_conflicts(perf_conflicts)
`endif
   );

   typedef struct packed {logic rw; logic [AW-1:0] addr; logic [TW-1:0] tag;} req_t;
   typedef struct packed {logic [DW-1:0] d; logic [MW-1:0] m;} beat_t;
   typedef struct packed {logic c; logic [TW-2:0] t; logic [DW-1:0] d;} resp_t;
   req_t  q_req[$];
   beat_t q_dat[$];
   resp_t q_rsp[$];
   int n_chk = 0, n_fail = 0;
   // reference model: next client in turn, client holding a stalled grant, write beats still owed
   int ptr = 0, lockc = -1, beats = 0;
   logic ic_acc = 1'b0, dc_acc = 1'b0;
   logic e_mv = 1'b0, e_icr = 1'b0, e_dcr = 1'b0, e_dr = 1'b0, e_mdv = 1'b0;
   int p_ic, p_dc, p_rw, p_rdy, p_drdy, p_resp;

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic zero_inputs();
      ic_req_valid = 0; ic_req_addr = '0; ic_req_tag = '0;
      dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_tag = '0;
      dc_req_data_valid = 0; dc_req_data_bits = '0; dc_req_data_mask = '0;
      mem_req_ready = 0; mem_req_data_ready = 0;
      mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
      e_mv = 0; e_icr = 0; e_dcr = 0; e_dr = 0; e_mdv = 0;
      ptr = 0; lockc = -1; beats = 0; ic_acc = 0; dc_acc = 0;
   endtask

   task automatic cycle();
      int w;
      req_t r;
      resp_t s;
      @(posedge clk); #1;
      if (ic_acc) ic_req_valid = 0;
      if (dc_acc) dc_req_valid = 0;
      ic_acc = 0; dc_acc = 0;
      if (!ic_req_valid && $urandom_range(99) < p_ic) begin
         ic_req_valid = 1; ic_req_addr = AW'($urandom); ic_req_tag = (TW-1)'($urandom);
      end
      if (!dc_req_valid && $urandom_range(99) < p_dc) begin
         dc_req_valid = 1; dc_req_addr = AW'($urandom); dc_req_tag = (TW-1)'($urandom);
         dc_req_rw = $urandom_range(99) < p_rw;
      end
      mem_req_ready = $urandom_range(99) < p_rdy;
      mem_req_data_ready = $urandom_range(99) < p_drdy;
      dc_req_data_valid = 1'($urandom_range(1));
      dc_req_data_bits = rnd_data();
      dc_req_data_mask = MW'($urandom);
      mem_resp_valid = $urandom_range(99) < p_resp;
      mem_resp_tag = TW'($urandom);
      mem_resp_data = rnd_data();
      if (mem_resp_valid) begin
         s.c = mem_resp_tag[TW-1]; s.t = mem_resp_tag[TW-2:0]; s.d = mem_resp_data;
         q_rsp.push_back(s);
      end
      e_mv = 0; e_icr = 0; e_dcr = 0; e_dr = 0; e_mdv = 0;
      if (beats == 0) begin
         w = lockc >= 0 ? lockc : (ic_req_valid && dc_req_valid) ? ptr : ic_req_valid ? 0 : dc_req_valid ? 1 : -1;
         if (w >= 0) begin
            e_mv = 1; e_icr = w == 0 && mem_req_ready; e_dcr = w == 1 && mem_req_ready;
            if (mem_req_ready) begin
               r.rw = w == 1 && dc_req_rw;
               r.addr = w == 1 ? dc_req_addr : ic_req_addr;
               r.tag = {w == 1, w == 1 ? dc_req_tag : ic_req_tag};
               q_req.push_back(r);
               if (w == 1 && dc_req_rw) beats = DC;
               ptr = 1 - w; lockc = -1;
               ic_acc = w == 0; dc_acc = w == 1;
            end else lockc = w;
         end
      end else begin
         e_dr = mem_req_data_ready; e_mdv = dc_req_data_valid;
         if (dc_req_data_valid && mem_req_data_ready) begin
            q_dat.push_back('{d: dc_req_data_bits, m: dc_req_data_mask});
            beats--;
         end
      end
   endtask

   req_t m_r;
   beat_t m_b;
   resp_t m_s;
   always @(negedge clk) if (!reset) begin
      check("mem_req_valid", DW'(mem_req_valid), DW'(e_mv));
      check("ic_req_ready", DW'(ic_req_ready), DW'(e_icr));
      check("dc_req_ready", DW'(dc_req_ready), DW'(e_dcr));
      check("dc_req_data_ready", DW'(dc_req_data_ready), DW'(e_dr));
      check("mem_req_data_valid", DW'(mem_req_data_valid), DW'(e_mdv));
      if (mem_req_valid && mem_req_ready) begin
         if (q_req.size() == 0) check("req_unexpected", DW'(1), DW'(0));
         else begin
            m_r = q_req.pop_front();
            check("req_rw", DW'(mem_req_rw), DW'(m_r.rw));
            check("req_addr", DW'(mem_req_addr), DW'(m_r.addr));
            check("req_tag", DW'(mem_req_tag), DW'(m_r.tag));
         end
      end
      if (mem_req_data_valid && mem_req_data_ready) begin
         if (q_dat.size() == 0) check("beat_unexpected", DW'(1), DW'(0));
         else begin
            m_b = q_dat.pop_front();
            check("beat_data", mem_req_data_bits, m_b.d);
            check("beat_mask", DW'(mem_req_data_mask), DW'(m_b.m));
         end
      end
      check("resp_both", DW'(ic_resp_valid && dc_resp_valid), DW'(0));
      if (ic_resp_valid || dc_resp_valid) begin
         if (q_rsp.size() == 0) check("resp_unexpected", DW'(1), DW'(0));
         else begin
            m_s = q_rsp.pop_front();
            check("resp_client", DW'(dc_resp_valid), DW'(m_s.c));
            check("resp_tag", DW'(dc_resp_valid ? dc_resp_tag : ic_resp_tag), DW'(m_s.t));
            check("resp_data", dc_resp_valid ? dc_resp_data : ic_resp_data, m_s.d);
         end
      end
   end

   initial begin
      zero_inputs();
      ic_req_valid = 1; dc_req_valid = 1; mem_req_ready = 1; mem_req_data_ready = 1;
      dc_req_data_valid = 1; mem_resp_valid = 1; mem_resp_tag = 5'h11;
      #12;
      check("reset_outputs", DW'({ic_req_ready, ic_resp_valid, dc_req_ready, dc_req_data_ready,
             dc_resp_valid, mem_req_valid, mem_req_data_valid}), DW'(0));
      zero_inputs();
      @(posedge clk); #1 reset = 0;
      // both clients always valid with reads: strict alternation from icache
      p_ic = 100; p_dc = 100; p_rw = 0; p_rdy = 100; p_drdy = 50; p_resp = 0;
      repeat (8) cycle();
      p_ic = 40; p_dc = 40; p_rw = 50; p_rdy = 70; p_drdy = 60; p_resp = 30;
      repeat (2000) cycle();
      p_ic = 100; p_dc = 100; p_rw = 100; p_rdy = 100; p_drdy = 100; p_resp = 0;
      for (int i = 0; i < 200 && beats != 2; i++) cycle();
      check("burst_reached_beat2", DW'(beats), DW'(2));
      @(posedge clk); #1;
      dc_req_data_valid = 1; mem_req_data_ready = 1; mem_req_ready = 1;
      mem_resp_valid = 1; mem_resp_tag = 5'h11;
      #1 check("wdata_before_reset", DW'(mem_req_data_valid), DW'(1));
      reset = 1;
      #1 check("async_reset_outputs", DW'({ic_req_ready, ic_resp_valid, dc_req_ready, dc_req_data_ready,
             dc_resp_valid, mem_req_valid, mem_req_data_valid}), DW'(0));
      zero_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      p_ic = 100; p_dc = 100; p_rw = 0; p_rdy = 100; p_resp = 0;
      repeat (5) cycle();
`ifdef MEM_ARB_PERF_EN
      check("perf_conflicts", DW'(perf_conflicts), DW'(4));
      check("perf_ic_grants", DW'(perf_ic_grants), DW'(2));
      check("perf_dc_grants", DW'(perf_dc_grants), DW'(2));
`endif
      p_ic = 30; p_dc = 30; p_rw = 50; p_rdy = 60; p_drdy = 50; p_resp = 40;
      repeat (600) cycle();
      p_ic = 0; p_dc = 0; p_rdy = 100; p_drdy = 100; p_resp = 0;
      repeat (40) cycle();
      @(negedge clk); #1;
      check("req_queue_empty", DW'(q_req.size()), DW'(0));
      check("beat_queue_empty", DW'(q_dat.size()), DW'(0));
      check("resp_queue_empty", DW'(q_rsp.size()), DW'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
